mem_access_stage: RTL and testbench

- Memory-access stage of the in-order RISC-V core. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Executes loads and stores on a req/gnt/rvalid data-memory bus and formats load data (byte/half extraction, sign/zero extension).
- Stalls upstream while a bus transaction is in flight and presents one result, or a nop bubble, per cycle to MEM/WB.

---
 rtl/mem_access_stage_if.sv | 22 ++
 rtl/mem_access_stage.sv | 209 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory bus of the MEM stage: req/gnt request phase, rvalid/rdata
// response phase. master = the pipeline stage, slave = the memory.
interface mem_access_stage_if;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_gnt_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;

   modport master (
      output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
      input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
   );

   modport slave (
      input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
      output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
   );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage of the in-order RISC-V core.
// Runs loads/stores on the req/gnt/rvalid bus, formats load data and stalls
// upstream while a transaction is in flight. TIMEOUT > 0 aborts a stuck
// REQ/RESP phase after TIMEOUT cycles with a one-cycle bus_err_o pulse.
// Optional build macro MISALIGN_TRAP_EN: adds misalign_o and traps
// misaligned halfword/word accesses instead of silently aligning them.
module mem_access_stage #(
   parameter int unsigned TIMEOUT = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        alu_out_i,
   input  logic [31:0]        store_data_i,
   input  logic [6:0]         opcode_i,
   input  logic [2:0]         funct3_i,
   input  logic [6:0]         funct7_i,
   input  logic [4:0]         rd_i,
   output logic               stall_o,
   mem_access_stage_if.master dmem,
   output logic               bus_err_o,
   output logic [31:0]        alu_out_o,
   output logic [6:0]         opcode_o,
   output logic [2:0]         funct3_o,
   output logic [6:0]         funct7_o,
   output logic [4:0]         rd_o,
   output logic [31:0]        load_out_o
`ifdef MISALIGN_TRAP_EN
   ,
   output logic               misalign_o
`endif
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   // addi x0, x0, 0
   localparam logic [6:0] NOP_OP   = 7'b0010011;
   localparam logic [2:0] NOP_F3   = 3'b000;
   localparam logic [6:0] NOP_F7   = 7'b0000000;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

   state_t      r_state;
   logic [31:0] r_addr;
   logic [31:0] r_sdata;
   logic [31:0] r_load;
   logic [31:0] r_cnt;
   logic [6:0]  r_op;
   logic [6:0]  r_f7;
   logic [2:0]  r_f3;
   logic [4:0]  r_rd;
   logic        r_we;
   logic        r_err;

   logic        w_is_mem;
   logic        w_timeout;
   logic        w_trap;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_fmt;

`ifdef MISALIGN_TRAP_EN
   logic        r_mis;
   logic        w_mis_in;

   assign w_mis_in = ((funct3_i[1:0] == 2'b01) && alu_out_i[0]) ||
                     (funct3_i[1] && (alu_out_i[1:0] != 2'b00));
   assign w_trap     = r_err | r_mis;
   assign misalign_o = (r_state == S_DONE) && r_mis;
`else
   assign w_trap = r_err;
`endif

   assign w_is_mem  = (opcode_i == OP_LOAD) || (opcode_i == OP_STORE);
   assign w_timeout = (TIMEOUT != 0) && (r_cnt == 32'(TIMEOUT - 1));
   assign stall_o   = (r_state != S_IDLE);
   assign bus_err_o = (r_state == S_DONE) && r_err;

   // Load formatting: pick byte/halfword lane by held address, then extend
   always_comb begin
      w_byte = 8'(dmem.dmem_rdata_i >> {r_addr[1:0], 3'b000});
      w_half = r_addr[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];
      case (r_f3)
         3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_fmt = {24'b0, w_byte};
         3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
         3'b101:  w_fmt = {16'b0, w_half};
         default: w_fmt = dmem.dmem_rdata_i;
      endcase
   end

   // Bus drive: only in REQ, sourced from hold registers so it is stable until gnt
   always_comb begin
      dmem.dmem_req_o   = 1'b0;
      dmem.dmem_we_o    = 1'b0;
      dmem.dmem_addr_o  = '0;
      dmem.dmem_wdata_o = '0;
      dmem.dmem_be_o    = '0;
      if (r_state == S_REQ) begin
         dmem.dmem_req_o  = 1'b1;
         dmem.dmem_we_o   = r_we;
         dmem.dmem_addr_o = {r_addr[31:2], 2'b00};
         case (r_f3[1:0])
            2'b00: begin
               dmem.dmem_wdata_o = {4{r_sdata[7:0]}};
               dmem.dmem_be_o    = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
               dmem.dmem_wdata_o = {2{r_sdata[15:0]}};
               dmem.dmem_be_o    = r_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
               dmem.dmem_wdata_o = r_sdata;
               dmem.dmem_be_o    = 4'b1111;
            end
         endcase
      end
   end

   // WB outputs: IDLE passes non-memory ops through, DONE presents the held op, else bubble
   always_comb begin
      alu_out_o  = '0;
      opcode_o   = NOP_OP;
      funct3_o   = NOP_F3;
      funct7_o   = NOP_F7;
      rd_o       = '0;
      load_out_o = '0;
      if ((r_state == S_IDLE) && !w_is_mem) begin
         alu_out_o = alu_out_i;
         opcode_o  = opcode_i;
         funct3_o  = funct3_i;
         funct7_o  = funct7_i;
         rd_o      = rd_i;
      end else if ((r_state == S_DONE) && !w_trap) begin
         alu_out_o  = r_addr;
         opcode_o   = r_op;
         funct3_o   = r_f3;
         funct7_o   = r_f7;
         rd_o       = r_rd;
         load_out_o = r_load;
      end
   end

   // Transaction FSM with hold registers and REQ/RESP timeout counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_sdata <= '0;
         r_load  <= '0;
         r_cnt   <= '0;
         r_op    <= '0;
         r_f7    <= '0;
         r_f3    <= '0;
         r_rd    <= '0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         r_mis   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_is_mem) begin
                  r_addr  <= alu_out_i;
                  r_sdata <= store_data_i;
                  r_op    <= opcode_i;
                  r_f3    <= funct3_i;
                  r_f7    <= funct7_i;
                  r_rd    <= rd_i;
                  r_we    <= (opcode_i == OP_STORE);
                  r_load  <= '0;
                  r_err   <= 1'b0;
                  r_cnt   <= '0;
`ifdef MISALIGN_TRAP_EN
                  r_mis   <= w_mis_in;
                  r_state <= w_mis_in ? S_DONE : S_REQ;
`else
                  r_state <= S_REQ;
`endif
               end
            end
            S_REQ: begin
               if (dmem.dmem_gnt_i) begin
                  r_cnt   <= '0;
                  r_state <= r_we ? S_DONE : S_RESP;
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            S_RESP: begin
               if (dmem.dmem_rvalid_i) begin
                  r_load  <= w_fmt;
                  r_state <= S_DONE;
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: table vectors, hand-written corner
// sequences and randomized ops checked against a behavioural model.
module tb_mem_access_stage;
   localparam logic [6:0] LOAD  = 7'b0000011;
   localparam logic [6:0] STORE = 7'b0100011;
   localparam logic [6:0] ADD   = 7'b0110011;
   localparam logic [6:0] NOP   = 7'b0010011;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic [31:0] alu_i, sd_i, alu_o, ld_o;
   logic [6:0]  op_i, f7_i, op_o, f7_o;
   logic [2:0]  f3_i, f3_o;
   logic [4:0]  rd_i, rd_o;
   logic        stall, err;
   mem_access_stage_if bus0();

   logic [31:0] t_alu_i, t_sd_i, t_alu_o, t_ld_o;
   logic [6:0]  t_op_i, t_f7_i, t_op_o, t_f7_o;
   logic [2:0]  t_f3_i, t_f3_o;
   logic [4:0]  t_rd_i, t_rd_o;
   logic        t_stall, t_err;
   mem_access_stage_if bus1();
`ifdef MISALIGN_TRAP_EN
   logic mis0, mis1;
`endif

   mem_access_stage dut0 (
      .clk(clk), .rst(rst), .alu_out_i(alu_i), .store_data_i(sd_i),
      .opcode_i(op_i), .funct3_i(f3_i), .funct7_i(f7_i), .rd_i(rd_i),
      .stall_o(stall), .dmem(bus0), .bus_err_o(err), .alu_out_o(alu_o),
      .opcode_o(op_o), .funct3_o(f3_o), .funct7_o(f7_o), .rd_o(rd_o),
      .load_out_o(ld_o)
`ifdef MISALIGN_TRAP_EN
      , .misalign_o(mis0)
`endif
   );

   mem_access_stage #(.TIMEOUT(4)) dut1 (
      .clk(clk), .rst(rst), .alu_out_i(t_alu_i), .store_data_i(t_sd_i),
      .opcode_i(t_op_i), .funct3_i(t_f3_i), .funct7_i(t_f7_i), .rd_i(t_rd_i),
      .stall_o(t_stall), .dmem(bus1), .bus_err_o(t_err), .alu_out_o(t_alu_o),
      .opcode_o(t_op_o), .funct3_o(t_f3_o), .funct7_o(t_f7_o), .rd_o(t_rd_o),
      .load_out_o(t_ld_o)
`ifdef MISALIGN_TRAP_EN
      , .misalign_o(mis1)
`endif
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] addr, sdata, rdata;
      int          gnt_dly, rv_dly;
      logic [31:0] e_load, e_addr, e_wdata;
      logic [3:0]  e_be;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic to_drive();
      @(posedge clk); #1;
   endtask
   task automatic to_sample();
      @(negedge clk);
   endtask

   // Reference model of load formatting and store lane placement
   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] b, h;
      b = (d >> (8 * (a % 4))) & 32'hFF;
      h = ((a % 4) >= 2) ? (d >> 16) : (d & 32'hFFFF);
      case (f3)
         3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd5:    return h;
         default: return d;
      endcase
   endfunction
   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      case (f3 % 4)
         0:       return 4'(1 << (a % 4));
         1:       return ((a % 4) >= 2) ? 4'd12 : 4'd3;
         default: return 4'd15;
      endcase
   endfunction
   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3 % 4)
         0:       return (d & 32'hFF) * 32'h0101_0101;
         1:       return (d & 32'hFFFF) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                               input logic [31:0] addr, sdata, rdata, input int g, r,
                               input logic [31:0] e_load, e_addr, e_wdata, input logic [3:0] e_be);
      vec_t v;
      v.op = op; v.f3 = f3; v.rd = rd; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
      v.gnt_dly = g; v.rv_dly = r; v.e_load = e_load; v.e_addr = e_addr;
      v.e_wdata = e_wdata; v.e_be = e_be;
      return v;
   endfunction

   // One op on dut0: IDLE cycle, REQ with gnt after gnt_dly, RESP for loads, DONE
   task automatic apply(input vec_t v);
      logic is_mem, is_ld;
      is_mem = (v.op == LOAD) || (v.op == STORE);
      is_ld  = (v.op == LOAD);
      to_drive();
      op_i = v.op; f3_i = v.f3; f7_i = 7'h20; rd_i = v.rd; alu_i = v.addr; sd_i = v.sdata;
      bus0.dmem_gnt_i = 1'b0; bus0.dmem_rvalid_i = 1'b0;
      to_sample();
      if (!is_mem) begin
         chk("pass_alu", alu_o, v.addr);
         chk("pass_rd", 32'(rd_o), 32'(v.rd));
         chk("pass_op", 32'(op_o), 32'(v.op));
         chk("pass_f3", 32'(f3_o), 32'(v.f3));
         chk("pass_stall_req_ld", {30'b0, stall, bus0.dmem_req_o} | ld_o, 32'd0);
         return;
      end
      chk("idle_bubble", {20'b0, stall, rd_o, op_o}, {20'b0, 1'b0, 5'd0, NOP});
      chk("idle_req", 32'(bus0.dmem_req_o), 32'd0);
      for (int c = 0; c <= v.gnt_dly; c++) begin
         to_drive();
         op_i = ADD; alu_i = $urandom; sd_i = $urandom; rd_i = 5'($urandom); f3_i = 3'($urandom);
         bus0.dmem_gnt_i = (c == v.gnt_dly); bus0.dmem_rvalid_i = 1'b1; bus0.dmem_rdata_i = $urandom;
         to_sample();
         chk("req_req_we_stall", {29'b0, bus0.dmem_req_o, bus0.dmem_we_o, stall}, {29'b0, 1'b1, !is_ld, 1'b1});
         chk("req_addr", bus0.dmem_addr_o, v.e_addr);
         chk("req_bubble", {25'b0, rd_o, op_o} | alu_o, {25'b0, 5'd0, NOP});
         if (!is_ld) begin
            chk("req_wdata", bus0.dmem_wdata_o, v.e_wdata);
            chk("req_be", 32'(bus0.dmem_be_o), 32'(v.e_be));
         end
      end
      if (is_ld) begin
         for (int c = 0; c <= v.rv_dly; c++) begin
            to_drive();
            bus0.dmem_gnt_i = 1'b0; bus0.dmem_rvalid_i = (c == v.rv_dly);
            bus0.dmem_rdata_i = (c == v.rv_dly) ? v.rdata : $urandom;
            to_sample();
            chk("resp_req_stall", {30'b0, bus0.dmem_req_o, stall}, 32'd1);
            chk("resp_rd", 32'(rd_o), 32'd0);
         end
      end
      to_drive();
      bus0.dmem_gnt_i = 1'b0; bus0.dmem_rvalid_i = 1'b0;
      to_sample();
      chk("done_stall_req_err", {29'b0, stall, bus0.dmem_req_o, err}, 32'd4);
      chk("done_rd", 32'(rd_o), 32'(v.rd));
      chk("done_op", 32'(op_o), 32'(v.op));
      chk("done_f3", 32'(f3_o), 32'(v.f3));
      chk("done_alu", alu_o, v.addr);
      chk("done_load", ld_o, v.e_load);
   endtask

   vec_t tbl[9];
   vec_t rv;
   int   err_cyc, err_pulses, req_cyc;
   logic [6:0] nonmem[4] = '{ADD, NOP, 7'b1100011, 7'b0110111};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      op_i = ADD; f3_i = 3'd0; f7_i = 7'd0; rd_i = 5'd5; alu_i = 32'h55; sd_i = '0;
      t_op_i = ADD; t_f3_i = 3'd0; t_f7_i = 7'd0; t_rd_i = 5'd6; t_alu_i = 32'h66; t_sd_i = '0;
      bus0.dmem_gnt_i = 1'b0; bus0.dmem_rvalid_i = 1'b0; bus0.dmem_rdata_i = '0;
      bus1.dmem_gnt_i = 1'b0; bus1.dmem_rvalid_i = 1'b0; bus1.dmem_rdata_i = '0;
      to_sample();
      chk("rst_stall_err", {30'b0, stall, err}, 32'd0);
      chk("rst_bus", {bus0.dmem_req_o, bus0.dmem_we_o, bus0.dmem_be_o} | bus0.dmem_addr_o | bus0.dmem_wdata_o, 32'd0);
      chk("rst_wb_pass", {20'b0, rd_o, op_o} ^ alu_o, {20'b0, 5'd5, ADD} ^ 32'h55);
      @(negedge clk); rst = 1'b0;

      tbl[0] = mk(ADD,   3'd0, 5'd5,  32'h10,  0, 0, 0, 0, 0, 0, 0, 0);
      tbl[1] = mk(LOAD,  3'd0, 5'd3,  32'h103, 0, 32'h80FF_0011, 0, 0, 32'hFFFF_FF80, 32'h100, 0, 0);
      tbl[2] = mk(STORE, 3'd1, 5'd9,  32'h202, 32'h1234_ABCD, 0, 3, 0, 0, 32'h200, 32'hABCD_ABCD, 4'b1100);
      tbl[3] = mk(LOAD,  3'd5, 5'd12, 32'h0,   0, 32'h0000_8001, 0, 0, 32'h0000_8001, 32'h0, 0, 0);
      tbl[4] = mk(LOAD,  3'd1, 5'd13, 32'h6,   0, 32'h8001_1234, 1, 2, 32'hFFFF_8001, 32'h4, 0, 0);
      tbl[5] = mk(LOAD,  3'd4, 5'd14, 32'h21,  0, 32'h0000_F000, 0, 1, 32'h0000_00F0, 32'h20, 0, 0);
      tbl[6] = mk(STORE, 3'd0, 5'd1,  32'h101, 32'h0000_00A5, 0, 0, 0, 0, 32'h100, 32'hA5A5_A5A5, 4'b0010);
      tbl[7] = mk(STORE, 3'd2, 5'd2,  32'h10,  32'hCAFE_F00D, 0, 2, 0, 0, 32'h10, 32'hCAFE_F00D, 4'b1111);
      tbl[8] = mk(LOAD,  3'd2, 5'd31, 32'h44,  0, 32'hDEAD_BEEF, 2, 3, 32'hDEAD_BEEF, 32'h44, 0, 0);
      for (int i = 0; i < 9; i++) apply(tbl[i]);

      // Instruction stalled behind a load shows up on WB right after DONE
      apply(tbl[3]);
      to_drive();
      op_i = ADD; rd_i = 5'd21; alu_i = 32'h777;
      to_sample();
      chk("behind_stall", 32'(stall), 32'd0);
      chk("behind_wb", {20'b0, rd_o, op_o} ^ alu_o, {20'b0, 5'd21, ADD} ^ 32'h777);

`ifdef MISALIGN_TRAP_EN
      to_drive();
      op_i = LOAD; f3_i = 3'd2; rd_i = 5'd8; alu_i = 32'h2;
      to_sample();
      chk("mis_idle", {26'b0, mis0, bus0.dmem_req_o, stall, rd_o == 5'd0, 2'b0}, 32'h4);
      to_drive();
      op_i = ADD;
      to_sample();
      chk("mis_done", {26'b0, mis0, bus0.dmem_req_o, stall, rd_o == 5'd0, op_o == NOP, ld_o == 0}, 32'h2F);
      to_drive();
      to_sample();
      chk("mis_after", {30'b0, mis0, stall}, 32'd0);
`else
      apply(mk(LOAD, 3'd2, 5'd8, 32'h7, 0, 32'h0123_4567, 0, 0, 32'h0123_4567, 32'h4, 0, 0));
`endif

      for (int i = 0; i < 40; i++) begin
         int k;
         k = $urandom_range(0, 2);
         rv.addr = $urandom; rv.sdata = $urandom; rv.rdata = $urandom; rv.rd = 5'($urandom);
         rv.gnt_dly = $urandom_range(0, 3); rv.rv_dly = $urandom_range(0, 3);
         if (k == 0) begin
            rv.op = nonmem[$urandom_range(0, 3)]; rv.f3 = 3'($urandom);
         end else if (k == 1) begin
            rv.op = LOAD;
            case ($urandom_range(0, 4))
               0: rv.f3 = 3'd0; 1: rv.f3 = 3'd1; 2: rv.f3 = 3'd2; 3: rv.f3 = 3'd4; default: rv.f3 = 3'd5;
            endcase
         end else begin
            rv.op = STORE; rv.f3 = 3'($urandom_range(0, 2));
         end
`ifdef MISALIGN_TRAP_EN
         if (rv.f3[1:0] == 2'b01) rv.addr = rv.addr & ~32'd1;
         if (rv.f3[1])            rv.addr = rv.addr & ~32'd3;
`endif
         rv.e_addr  = rv.addr & ~32'd3;
         rv.e_load  = (k == 1) ? m_load(rv.f3, rv.addr, rv.rdata) : 32'd0;
         rv.e_be    = m_be(rv.f3, rv.addr);
         rv.e_wdata = m_wdata(rv.f3, rv.sdata);
         apply(rv);
      end

      // TIMEOUT=4, no gnt: four REQ cycles, then DONE with bus_err
      to_drive();
      t_op_i = LOAD; t_f3_i = 3'd2; t_rd_i = 5'd7; t_alu_i = 32'h40;
      bus1.dmem_gnt_i = 1'b0; bus1.dmem_rvalid_i = 1'b0;
      to_sample();
      err_cyc = 0; err_pulses = 0; req_cyc = 0;
      for (int c = 1; c <= 20; c++) begin
         to_drive();
         t_op_i = ADD; t_rd_i = 5'd17;
         to_sample();
         if (bus1.dmem_req_o) req_cyc++;
         if (t_err) begin
            err_pulses++; err_cyc = c;
            chk("to_done_bubble", {24'b0, t_rd_o, bus1.dmem_req_o, t_op_o == NOP, t_ld_o == 0}, 32'h3);
         end
         if (!t_stall) break;
      end
      chk("to_req_err_cycle", 32'(err_cyc), 32'd5);
      chk("to_err_pulses", 32'(err_pulses), 32'd1);
      chk("to_req_cycles", 32'(req_cyc), 32'd4);
      chk("to_after_wb", {24'b0, t_rd_o, t_err, t_stall, t_op_o == ADD}, {24'b0, 5'd17, 3'b001});

      // TIMEOUT=4 in RESP: gnt at once, no rvalid -> DONE six cycles after IDLE
      to_drive();
      t_op_i = LOAD; t_rd_i = 5'd9;
      to_sample();
      err_cyc = 0;
      for (int c = 1; c <= 20; c++) begin
         to_drive();
         t_op_i = ADD; bus1.dmem_gnt_i = (c == 1);
         to_sample();
         if (t_err && err_cyc == 0) err_cyc = c;
         if (!t_stall) break;
      end
      chk("to_resp_err_cycle", 32'(err_cyc), 32'd6);

      // Async reset mid-RESP and mid-REQ
      to_drive();
      t_op_i = LOAD; t_rd_i = 5'd4; t_alu_i = 32'h80;
      to_sample();
      to_drive();
      t_op_i = ADD; t_rd_i = 5'd11; bus1.dmem_gnt_i = 1'b1;
      to_sample();
      chk("rst_pre_req", 32'(bus1.dmem_req_o), 32'd1);
      to_drive();
      bus1.dmem_gnt_i = 1'b0;
      #2 rst = 1'b1; #1;
      chk("rst_resp", {27'b0, t_stall, bus1.dmem_req_o, t_err, t_rd_o == 5'd11, t_op_o == ADD}, 32'h3);
      @(negedge clk); rst = 1'b0;
      to_drive();
      t_op_i = LOAD; t_rd_i = 5'd4;
      to_sample();
      to_drive();
      t_op_i = ADD;
      #2;
      chk("rst_req_pre", 32'(bus1.dmem_req_o), 32'd1);
      rst = 1'b1; #1;
      chk("rst_req", {30'b0, t_stall, bus1.dmem_req_o}, 32'd0);
      @(negedge clk); rst = 1'b0;

      // Clean load after reset
      to_drive();
      t_op_i = LOAD; t_f3_i = 3'd2; t_rd_i = 5'd19; t_alu_i = 32'h88;
      to_sample();
      to_drive();
      bus1.dmem_gnt_i = 1'b1;
      to_sample();
      chk("post_rst_addr", bus1.dmem_addr_o, 32'h88);
      to_drive();
      bus1.dmem_gnt_i = 1'b0; bus1.dmem_rvalid_i = 1'b1; bus1.dmem_rdata_i = 32'h1122_3344;
      to_sample();
      to_drive();
      bus1.dmem_rvalid_i = 1'b0;
      to_sample();
      chk("post_rst_load", t_ld_o, 32'h1122_3344);
      chk("post_rst_rd", 32'(t_rd_o), 32'd19);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
